// File: rtl/header_sched_if.sv
// Avalon-ST packet stream bundle shared by header_sched and its neighbours.
interface avalon_st_if #(
  parameter int DATA_WIDTH  = 128,
  parameter int EMPTY_WIDTH = 4
);
  logic [DATA_WIDTH-1:0]  data;
  logic                   sop;
  logic                   eop;
  logic                   valid;
  logic                   ready;
  logic [EMPTY_WIDTH-1:0] empty;

  modport master (
    output data, sop, eop, valid, empty,
    input  ready
  );

  modport slave (
    input  data, sop, eop, valid, empty,
    output ready
  );
endinterface

// File: rtl/header_sched.sv
// header_sched: packet round-robin arbiter in front of a header-insertion stage.
// Define HEADER_SCHED_PKT_CNT_EN to add per-port eop counters (pkt_cnt, cnt_clr).
module header_sched #(
  parameter int N_PORTS     = 4,
  parameter int DATA_WIDTH  = 128,
  parameter int HEADER_SIZE = 256,
  parameter int EMPTY_WIDTH = 4,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  avalon_st_if.slave                     in_st [N_PORTS],
  input  logic [N_PORTS*HEADER_SIZE-1:0] port_hdr,
  input  logic [N_PORTS-1:0]             port_en,
  avalon_st_if.master                    out_st,
  output logic [HEADER_SIZE-1:0]         header_data,
  output logic                           header_vld,
  output logic [$clog2(N_PORTS)-1:0]     grant_id,
  output logic                           busy,
  output logic                           sop_err
`ifdef HEADER_SCHED_PKT_CNT_EN
  ,
  input  logic                           cnt_clr,
  output logic [N_PORTS*CNT_WIDTH-1:0]   pkt_cnt
`endif
);

  localparam int IW  = $clog2(N_PORTS);
  localparam int IW1 = IW + 1;

  typedef enum logic [1:0] {
    IDLE_ST,
    HDR_ST,
    PASS_ST
  } state_t;

  state_t                 state;
  logic [IW-1:0]          rr_ptr;
  logic [IW-1:0]          nxt;
  logic [IW1-1:0]         sum;
  logic                   first;
  logic [N_PORTS-1:0]     in_vld;
  logic [N_PORTS-1:0]     in_sop;
  logic [N_PORTS-1:0]     in_eop;
  logic [N_PORTS-1:0]     req;
  logic [DATA_WIDTH-1:0]  in_data  [N_PORTS];
  logic [EMPTY_WIDTH-1:0] in_empty [N_PORTS];
  logic [HEADER_SIZE-1:0] hdr_arr  [N_PORTS];
  logic                   pass;
  logic                   beat;
  logic                   fin;

  assign pass = (state == PASS_ST);

  for (genvar g = 0; g < N_PORTS; g++) begin : g_port
    assign in_vld[g]   = in_st[g].valid;
    assign in_sop[g]   = in_st[g].sop;
    assign in_eop[g]   = in_st[g].eop;
    assign in_data[g]  = in_st[g].data;
    assign in_empty[g] = in_st[g].empty;
    assign hdr_arr[g]  = port_hdr[HEADER_SIZE*g +: HEADER_SIZE];
    assign in_st[g].ready = pass && out_st.ready &&
                            (grant_id == IW'(g));
`ifdef HEADER_SCHED_PKT_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (cnt_clr) begin
        cnt_q <= '0;
      end else if (fin && grant_id == IW'(g)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
    assign pkt_cnt[CNT_WIDTH*g +: CNT_WIDTH] = cnt_q;
`endif
  end

  assign req          = in_vld & port_en;
  assign out_st.valid = pass && in_vld[grant_id];
  assign out_st.data  = in_data[grant_id];
  assign out_st.sop   = in_sop[grant_id];
  assign out_st.eop   = in_eop[grant_id];
  assign out_st.empty = in_empty[grant_id];

  assign beat    = pass && in_vld[grant_id] && out_st.ready;
  assign fin     = beat && in_eop[grant_id];
  assign sop_err = beat && first && !in_sop[grant_id];

  // Scan downward so the lowest distance from rr_ptr wins.
  always_comb begin
    nxt = rr_ptr;
    sum = '0;
    for (int i = N_PORTS-1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + IW1'(i);
      if (sum >= IW1'(N_PORTS)) sum = sum - IW1'(N_PORTS);
      if (req[sum[IW-1:0]]) nxt = sum[IW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE_ST;
      rr_ptr      <= '0;
      grant_id    <= '0;
      header_vld  <= 1'b0;
      header_data <= '0;
      busy        <= 1'b0;
      first       <= 1'b0;
    end else begin
      header_vld <= 1'b0;
      unique case (1'b1)
        state == IDLE_ST: begin
          if (|req) begin
            state       <= HDR_ST;
            grant_id    <= nxt;
            header_data <= hdr_arr[nxt];
            header_vld  <= 1'b1;
            busy        <= 1'b1;
          end
        end
        state == HDR_ST: begin
          state <= PASS_ST;
          first <= 1'b1;
        end
        state == PASS_ST: begin
          if (beat) begin
            first <= 1'b0;
            if (in_eop[grant_id]) begin
              state  <= IDLE_ST;
              busy   <= 1'b0;
              rr_ptr <= (grant_id == IW'(N_PORTS-1)) ?
                        '0 : grant_id + 1'b1;
            end
          end
        end
        default: state <= IDLE_ST;
      endcase
    end
  end

endmodule

// File: tb/tb_header_sched.sv
// Self-checking bench for header_sched: vector table, directed corners,
// and randomized traffic against a packet-level round-robin model.
module tb_header_sched;

  localparam int N  = 4;
  localparam int DW = 128;
  localparam int HS = 256;
  localparam int EW = 4;
  localparam int CW = 32;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    logic          first;
  } word_t;

  typedef struct {
    logic [N-1:0] en;
    logic [N-1:0] req;
    int           len;
    int           g;
  } vec_t;

  logic            clk;
  logic            rst_n;
  logic [N*HS-1:0] port_hdr;
  logic [N-1:0]    port_en;
  logic [HS-1:0]   header_data;
  logic            header_vld;
  logic [1:0]      grant_id;
  logic            busy;
  logic            sop_err;
  logic            o_ready;
  logic [N-1:0]    s_valid;
  logic [N-1:0]    s_ready;
  word_t           s_word [N];
`ifdef HEADER_SCHED_PKT_CNT_EN
  logic            cnt_clr;
  logic [N*CW-1:0] pkt_cnt;
`endif

  avalon_st_if #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW)) in_st [N] ();
  avalon_st_if #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW)) out_st ();

  for (genvar g = 0; g < N; g++) begin : g_src
    assign in_st[g].valid = s_valid[g];
    assign in_st[g].data  = s_word[g].data;
    assign in_st[g].sop   = s_word[g].sop;
    assign in_st[g].eop   = s_word[g].eop;
    assign in_st[g].empty = s_word[g].empty;
    assign s_ready[g]     = in_st[g].ready;
  end
  assign out_st.ready = o_ready;

  header_sched #(
    .N_PORTS(N), .DATA_WIDTH(DW), .HEADER_SIZE(HS),
    .EMPTY_WIDTH(EW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_st(in_st),
    .port_hdr(port_hdr),
    .port_en(port_en),
    .out_st(out_st),
    .header_data(header_data),
    .header_vld(header_vld),
    .grant_id(grant_id),
    .busy(busy),
    .sop_err(sop_err)
`ifdef HEADER_SCHED_PKT_CNT_EN
    ,
    .cnt_clr(cnt_clr),
    .pkt_cnt(pkt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp, n_err;
  int cyc;
  int rr_m, g_cur, last_eop;
  int hdr_cnt, eop_cnt, beat_cnt, serr_cnt;
  int hdr_cyc, fb_cyc, eop_cyc;
  int rdy_mode;
  bit gap_en, hdr_chg, exp_first, in_pkt;
  logic [N-1:0]    prev_req;
  logic [N*HS-1:0] prev_hdr;
  word_t src_q [N][$];
  word_t mdl_q [N][$];
  word_t exp_q [$];
  int    gq [$];
  int    gapq [$];
  int    cnt_m [N];
  vec_t  tbl [10];

  function automatic void chk(string nm, logic [255:0] a, logic [255:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, a, e, cyc);
    end
  endfunction

  task automatic rand_hdr();
    for (int i = 0; i < N*HS/32; i++) port_hdr[i*32 +: 32] = $urandom;
  endtask

  task automatic load_pkt(int p, int len, bit bad);
    word_t w;
    for (int i = 0; i < len; i++) begin
      w.data  = {$urandom, $urandom, $urandom, $urandom};
      w.first = (i == 0);
      w.sop   = (i == 0) && !bad;
      w.eop   = (i == len-1);
      w.empty = w.eop ? EW'($urandom_range(0, 15)) : '0;
      src_q[p].push_back(w);
      mdl_q[p].push_back(w);
    end
  endtask

  task automatic clear_all();
    for (int p = 0; p < N; p++) begin
      src_q[p].delete();
      mdl_q[p].delete();
    end
    exp_q.delete();
    s_valid = '0;
  endtask

  task automatic model_reset();
    rr_m = 0; g_cur = 0; last_eop = -1;
    exp_first = 0; in_pkt = 0; prev_req = '0;
    for (int p = 0; p < N; p++) cnt_m[p] = 0;
  endtask

  task automatic drive();
    if (hdr_chg && $urandom_range(0, 9) == 0) rand_hdr();
    for (int p = 0; p < N; p++) begin
      if (src_q[p].size() > 0) begin
        s_word[p]  = src_q[p][0];
        s_valid[p] = src_q[p][0].first || !gap_en ||
                     ($urandom_range(0, 3) != 0);
      end else begin
        s_valid[p] = 1'b0;
      end
    end
    if (rdy_mode == 0) o_ready = 1'b1;
    else if (rdy_mode == 1) o_ready = ($urandom_range(0, 3) != 0);
    else o_ready = ~o_ready;
  endtask

  task automatic sb_check();
    word_t w;
    int    ge;
    logic  beat;
    beat = out_st.valid && o_ready;
    chk("busy", 256'(busy), 256'(header_vld || in_pkt));
    if (header_vld) begin
      hdr_cnt++;
      hdr_cyc = cyc;
      ge = -1;
      for (int i = N-1; i >= 0; i--)
        if (prev_req[(rr_m + i) % N]) ge = (rr_m + i) % N;
      chk("grant", 256'(grant_id), 256'(ge));
      g_cur = (ge >= 0) ? ge : int'(grant_id);
      chk("hdr_data", header_data, prev_hdr[g_cur*HS +: HS]);
      chk("hdr_overlap", 256'(exp_q.size()), 256'(0));
      gq.push_back(g_cur);
      if (mdl_q[g_cur].size() == 0) chk("pkt_avail", 256'(0), 256'(1));
      while (mdl_q[g_cur].size() > 0) begin
        w = mdl_q[g_cur].pop_front();
        exp_q.push_back(w);
        if (w.eop) break;
      end
      exp_first = 1;
      in_pkt    = 1;
    end
`ifdef HEADER_SCHED_PKT_CNT_EN
    if (cnt_clr) for (int p = 0; p < N; p++) cnt_m[p] = 0;
`endif
    if (beat) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", 256'(1), 256'(0));
      end else begin
        w = exp_q.pop_front();
        beat_cnt++;
        chk("data", 256'(out_st.data), 256'(w.data));
        chk("sop", 256'(out_st.sop), 256'(w.sop));
        chk("eop", 256'(out_st.eop), 256'(w.eop));
        chk("empty", 256'(out_st.empty), 256'(w.empty));
        chk("sop_err", 256'(sop_err), 256'(exp_first && !w.sop));
        if (exp_first) begin
          fb_cyc = cyc;
          if (last_eop >= 0) gapq.push_back(cyc - last_eop);
        end
        exp_first = 0;
        if (w.eop) begin
          eop_cnt++;
          eop_cyc  = cyc;
          last_eop = cyc;
          rr_m     = (g_cur + 1) % N;
          in_pkt   = 0;
`ifdef HEADER_SCHED_PKT_CNT_EN
          if (!cnt_clr) cnt_m[g_cur]++;
`endif
        end
      end
    end else begin
      chk("sop_err_idle", 256'(sop_err), 256'(0));
    end
    if (sop_err) serr_cnt++;
    prev_req = s_valid & port_en;
    prev_hdr = port_hdr;
  endtask

  task automatic tick();
    logic [N-1:0] acc;
    @(negedge clk);
    cyc++;
    sb_check();
    acc = s_valid & s_ready;
    @(posedge clk);
    #1;
    for (int p = 0; p < N; p++)
      if (acc[p]) void'(src_q[p].pop_front());
    drive();
  endtask

  task automatic wait_eops(int target, int bound);
    int n;
    n = 0;
    while (eop_cnt < target && n < bound) begin
      tick();
      n++;
    end
    if (eop_cnt < target) begin
      n_cmp++;
      n_err++;
      $display("FAIL eop_timeout: got %0d want %0d", eop_cnt, target);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_hdr_vld", 256'(header_vld), 256'(0));
    chk("rst_hdr_data", header_data, 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_grant", 256'(grant_id), 256'(0));
    chk("rst_sop_err", 256'(sop_err), 256'(0));
    chk("rst_out_valid", 256'(out_st.valid), 256'(0));
    chk("rst_in_ready", 256'(s_ready), 256'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_all();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
  endtask

  function automatic bit pending();
    bit r;
    r = (exp_q.size() != 0);
    for (int p = 0; p < N; p++) if (src_q[p].size() != 0) r = 1;
    return r;
  endfunction

  initial begin
    int e0, b0, h0, s0, n, load_c;
    n_cmp = 0; n_err = 0; cyc = 0;
    hdr_cnt = 0; eop_cnt = 0; beat_cnt = 0; serr_cnt = 0;
    hdr_cyc = 0; fb_cyc = 0; eop_cyc = 0;
    rdy_mode = 0; gap_en = 0; hdr_chg = 0;
    rst_n = 1'b0; port_en = '1; o_ready = 1'b1; s_valid = '0;
    for (int p = 0; p < N; p++) s_word[p] = '0;
`ifdef HEADER_SCHED_PKT_CNT_EN
    cnt_clr = 1'b0;
`endif
    rand_hdr();
    prev_hdr = port_hdr;
    do_reset();

    tbl[0] = '{4'b1111, 4'b0100, 3, 2};
    tbl[1] = '{4'b1111, 4'b1111, 2, 3};
    tbl[2] = '{4'b1111, 4'b1111, 1, 0};
    tbl[3] = '{4'b1010, 4'b1111, 2, 1};
    tbl[4] = '{4'b1010, 4'b1111, 1, 3};
    tbl[5] = '{4'b1010, 4'b1111, 4, 1};
    tbl[6] = '{4'b1111, 4'b0011, 2, 0};
    tbl[7] = '{4'b0111, 4'b1001, 1, 0};
    tbl[8] = '{4'b1111, 4'b0001, 3, 0};
    tbl[9] = '{4'b1111, 4'b1110, 2, 1};
    for (int r = 0; r < 10; r++) begin
      port_en = tbl[r].en;
      rand_hdr();
      for (int p = 0; p < N; p++)
        if (tbl[r].req[p]) load_pkt(p, tbl[r].len, 0);
      drive();
      load_c = cyc + 1;
      e0 = eop_cnt;
      wait_eops(e0 + 1, 60);
      chk("tbl_grant", 256'(grant_id), 256'(tbl[r].g));
      chk("tbl_hdr_lat", 256'(hdr_cyc), 256'(load_c + 1));
      chk("tbl_first_lat", 256'(fb_cyc), 256'(load_c + 2));
      chk("tbl_eop_lat", 256'(eop_cyc), 256'(load_c + 1 + tbl[r].len));
      port_en = '0;
      clear_all();
      drive();
      tick();
      chk("tbl_idle_busy", 256'(busy), 256'(0));
    end

    do_reset();
    port_en = '1; gq.delete(); gapq.delete(); e0 = eop_cnt;
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < N; p++) load_pkt(p, 2, 0);
    drive();
    wait_eops(e0 + 8, 200);
    chk("rr_count", 256'(gq.size()), 256'(8));
    foreach (gq[i]) chk("rr_order", 256'(gq[i]), 256'(i % N));
    chk("gap_count", 256'(gapq.size()), 256'(7));
    foreach (gapq[i]) chk("pkt_gap", 256'(gapq[i]), 256'(3));

    do_reset();
    port_en = '1; gq.delete(); e0 = eop_cnt; b0 = beat_cnt;
    load_pkt(1, 4, 0); load_pkt(1, 4, 0); load_pkt(2, 4, 0);
    drive();
    n = 0;
    while (beat_cnt == b0 && n < 20) begin tick(); n++; end
    port_en = 4'b1101;
    wait_eops(e0 + 2, 60);
    h0 = hdr_cnt;
    repeat (20) tick();
    chk("en_skip_hdr", 256'(hdr_cnt), 256'(h0));
    chk("en_skip_busy", 256'(busy), 256'(0));
    chk("en_count", 256'(gq.size()), 256'(2));
    if (gq.size() == 2) begin
      chk("en_order0", 256'(gq[0]), 256'(1));
      chk("en_order1", 256'(gq[1]), 256'(2));
    end
    port_en = '1;

    do_reset();
    s0 = serr_cnt; e0 = eop_cnt;
    load_pkt(0, 3, 1);
    drive();
    wait_eops(e0 + 1, 30);
    chk("sop_err_cnt", 256'(serr_cnt - s0), 256'(1));

    do_reset();
    load_pkt(1, 1, 0);
    drive();
    wait_eops(eop_cnt + 1, 30);
    load_pkt(2, 4, 0);
    rdy_mode = 2;
    drive();
    b0 = beat_cnt; n = 0;
    while (beat_cnt < b0 + 2 && n < 40) begin tick(); n++; end
    chk("pre_rst_beats", 256'(beat_cnt - b0), 256'(2));
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    clear_all();
    model_reset();
    rdy_mode = 0; o_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    gq.delete();
    load_pkt(0, 1, 0); load_pkt(3, 1, 0);
    drive();
    wait_eops(eop_cnt + 2, 40);
    chk("post_rst_count", 256'(gq.size()), 256'(2));
    if (gq.size() == 2) begin
      chk("post_rst_g0", 256'(gq[0]), 256'(0));
      chk("post_rst_g1", 256'(gq[1]), 256'(3));
    end

    do_reset();
    gap_en = 1; rdy_mode = 1; hdr_chg = 1;
    port_en = N'($urandom_range(1, 15));
    for (int p = 0; p < N; p++)
      for (int k = 0; k < 10; k++)
        load_pkt(p, $urandom_range(1, 6), $urandom_range(0, 7) == 0);
    drive();
    n = 0;
    while (pending() && n < 6000) begin
      tick();
      n++;
      if (n < 300 && $urandom_range(0, 19) == 0)
        port_en = N'($urandom_range(1, 15));
      if (n == 300) port_en = '1;
    end
    chk("rand_drain", 256'(pending()), 256'(0));
    for (int p = 0; p < N; p++)
      chk("rand_mdl_left", 256'(mdl_q[p].size()), 256'(0));
    gap_en = 0; rdy_mode = 0; hdr_chg = 0;

`ifdef HEADER_SCHED_PKT_CNT_EN
    for (int p = 0; p < N; p++)
      chk("pkt_cnt_rand", 256'(pkt_cnt[p*CW +: CW]), 256'(cnt_m[p]));
    do_reset();
    for (int k = 0; k < 5; k++) load_pkt(3, 1, 0);
    drive();
    wait_eops(eop_cnt + 5, 100);
    chk("pkt_cnt3", 256'(pkt_cnt[3*CW +: CW]), 256'(5));
    cnt_clr = 1'b1;
    load_pkt(3, 2, 0);
    drive();
    wait_eops(eop_cnt + 1, 30);
    cnt_clr = 1'b0;
    chk("pkt_cnt_clr", 256'(pkt_cnt[3*CW +: CW]), 256'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
